sum_lanes_accum: RTL

- Parametrised multi-cycle adder. Sums N_IN operands of W_IN bits using LANES parallel adders over a bounded number of cycles.
- Generalises the fixed 30-input / 4-adder / 9-cycle summer to any operand count, width and lane count.
- Adds a start/busy/done handshake, input capture and an optional signed mode.
- Sits between the operand register bank and downstream consumers of the reduced sum.

---
 rtl/sum_lanes_accum.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/sum_lanes_accum.sv
// rtl/sum_lanes_accum.sv - multi-cycle N_IN-operand summer built from LANES parallel accumulators
// Operands stream through the lanes over ceil(N_IN/LANES) cycles, then the lanes fold pairwise into lane 0.
module sum_lanes_accum #(
    parameter int N_IN   = 30,
    parameter int W_IN   = 5,
    parameter int LANES  = 4,
    parameter int SIGNED = 0,
    localparam int W_OUT = W_IN + $clog2(N_IN + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_IN*W_IN-1:0]   nums,
    input  logic                   start,
    output logic                   busy,
    output logic                   done,
    output logic [W_OUT-1:0]       sum
);

    localparam int A    = (N_IN + LANES - 1) / LANES;
    localparam int R    = $clog2(LANES);
    localparam int NP   = A * LANES;
    localparam int CMAX = (A > R) ? A : R;
    localparam int CW   = (CMAX < 2) ? 1 : $clog2(CMAX);

    typedef enum logic [1:0] {IDLE, ACCUM, REDUCE, DONE} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [W_OUT-1:0]  sum_q, sum_d;
    logic [W_IN-1:0]   ops_q [NP];
    logic [W_IN-1:0]   ops_d [NP];
    logic [W_OUT-1:0]  acc_q [LANES];
    logic [W_OUT-1:0]  acc_d [LANES];

    function automatic logic [W_OUT-1:0] extend(input logic [W_IN-1:0] v);
        if (SIGNED != 0) begin
            return {{(W_OUT-W_IN){v[W_IN-1]}}, v};
        end
        return {{(W_OUT-W_IN){1'b0}}, v};
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        sum_d   = sum_q;
        ops_d   = ops_q;
        acc_d   = acc_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    for (int i = 0; i < NP; i++) begin
                        ops_d[i] = '0;
                    end
                    for (int i = 0; i < N_IN; i++) begin
                        ops_d[i] = nums[i*W_IN +: W_IN];
                    end
                    for (int l = 0; l < LANES; l++) begin
                        acc_d[l] = '0;
                    end
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                // Lane l always consumes slot l; the operand window slides down by LANES each cycle.
                for (int l = 0; l < LANES; l++) begin
                    acc_d[l] = acc_q[l] + extend(ops_q[l]);
                end
                for (int i = 0; i < NP - LANES; i++) begin
                    ops_d[i] = ops_q[i + LANES];
                end
                for (int i = NP - LANES; i < NP; i++) begin
                    ops_d[i] = '0;
                end
                if (cnt_q == CW'(A - 1)) begin
                    cnt_d   = '0;
                    state_d = (R == 0) ? DONE : REDUCE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            REDUCE: begin
                for (int s = 0; s < R; s++) begin
                    for (int l = 0; l < LANES; l += (2 << s)) begin
                        if (cnt_q == CW'(s)) begin
                            acc_d[l] = acc_q[l] + acc_q[l + (1 << s)];
                        end
                    end
                end
                if (cnt_q == CW'(R - 1)) begin
                    cnt_d   = '0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                sum_d   = acc_q[0];
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sum_q   <= '0;
            for (int i = 0; i < NP; i++) begin
                ops_q[i] <= '0;
            end
            for (int l = 0; l < LANES; l++) begin
                acc_q[l] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            sum_q   <= sum_d;
            ops_q   <= ops_d;
            acc_q   <= acc_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;

endmodule
